// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment display scheduler.
// Contents: source IDs, FSM state encodings, default timing parameters and
// the round-robin pick helper used when choosing a rotating source.
package sseg_pkg;

  // Display content sources; SRC_NONE means nothing is on display.
  localparam logic [1:0] SRC_TIME  = 2'd0;
  localparam logic [1:0] SRC_DATE  = 2'd1;
  localparam logic [1:0] SRC_ALERT = 2'd2;
  localparam logic [1:0] SRC_NONE  = 2'd3;

  // Scheduler FSM state encodings.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ROTATE = 2'd1;
  localparam logic [1:0] ST_ALERT  = 2'd2;

  // Defaults for a 50 MHz clock: 1 s dwell, 0.25 s blink half-period.
  localparam int unsigned DEF_DWELL_CYCLES = 50_000_000;
  localparam int unsigned DEF_BLINK_CYCLES = 12_500_000;
  localparam int unsigned DEF_CNT_W        = 26;

  // Choose between the two rotating sources: the preferred one if it
  // requests, otherwise the other. Caller guarantees at least one requests.
  function automatic logic pick_rotating(input logic pref, input logic [1:0] rot_req);
    return rot_req[pref] ? pref : ~pref;
  endfunction

endpackage

// File: rtl/sseg_blink_gen.sv
// blink_gen: free-running blink phase generator.
// Ports:
//   clk           system clock
//   reset         synchronous active-high reset
//   blink_phase_o toggles every BLINK_CYCLES clocks, 0 after reset
module blink_gen #(
  parameter int unsigned BLINK_CYCLES = 12_500_000,
  parameter int unsigned CNT_W        = 26
) (
  input  logic clk,
  input  logic reset,
  output logic blink_phase_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_CYCLES - 1);

  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             phase_q, phase_d;

  // Count to the half-period end, then wrap and flip the phase.
  always_comb begin
    blink_cnt_d = blink_cnt_q + CNT_W'(1);
    phase_d     = phase_q;
    if (blink_cnt_q == CNT_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign blink_phase_o = phase_q;

endmodule

// File: rtl/sseg_scheduler.sv
// sseg_scheduler: time-shares a 4-digit seven-segment driver among
// time (0), date (1) and alert (2) sources. Time/date rotate round-robin
// with a fixed dwell; alert pre-empts while requested. All outputs are
// registered with one cycle of latency from the inputs.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req[2:0]              per-source display request (level)
//   blink[2:0]            per-source blink enable
//   data0..2, dp0..2      per-source digits ([15:12] = hexa3) and points
//   hexa3..hexa0, dps     digits/points to the display driver
//   digit_en              per-digit enable, 1 = lit
//   active_src            source on display, 3 = none
//   switched              one-cycle pulse when active_src changes
module sseg_scheduler
  import sseg_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = DEF_DWELL_CYCLES,
  parameter int unsigned BLINK_CYCLES = DEF_BLINK_CYCLES,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [2:0]  blink,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  input  logic [3:0]  dp0,
  input  logic [3:0]  dp1,
  input  logic [3:0]  dp2,
  output logic [3:0]  hexa3,
  output logic [3:0]  hexa2,
  output logic [3:0]  hexa1,
  output logic [3:0]  hexa0,
  output logic [3:0]  dps,
  output logic [3:0]  digit_en,
  output logic [1:0]  active_src,
  output logic        switched
);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       src_q, src_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic             rr_next_q, rr_next_d;

  logic [15:0]      disp_q, disp_d;
  logic [3:0]       dps_q, dps_d;
  logic [3:0]       den_q, den_d;
  logic             sw_q, sw_d;

  logic             blink_phase;
  logic             cur_rot;
  logic             idle_pick;
  logic [3:0]       blink_x;

  blink_gen #(
    .BLINK_CYCLES (BLINK_CYCLES),
    .CNT_W        (CNT_W)
  ) u_blink_gen (
    .clk           (clk),
    .reset         (reset),
    .blink_phase_o (blink_phase)
  );

  // Rotating source currently shown (meaningful in ROTATE only).
  assign cur_rot   = src_q[0];
  // Round-robin choice used whenever selection restarts from IDLE/ALERT.
  assign idle_pick = pick_rotating(rr_next_q, req[1:0]);
  // Pad so that SRC_NONE indexes a harmless zero.
  assign blink_x   = {1'b0, blink};

  // Next-state logic: source selection and dwell counting.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dwell_d   = dwell_q;
    rr_next_d = rr_next_q;

    case (state_q)
      ST_ROTATE: begin
        if (req[SRC_ALERT]) begin
          state_d = ST_ALERT;
          src_d   = SRC_ALERT;
          dwell_d = '0;
        end else if ((dwell_q == DWELL_LAST) || !req[cur_rot]) begin
          dwell_d = '0;
          if (req[~cur_rot]) begin
            src_d     = {1'b0, ~cur_rot};
            rr_next_d = cur_rot;
          end else if (req[cur_rot]) begin
            // Restart the dwell on the same source without a switch.
            rr_next_d = ~cur_rot;
          end else begin
            state_d = ST_IDLE;
            src_d   = SRC_NONE;
          end
        end else begin
          dwell_d = dwell_q + CNT_W'(1);
        end
      end

      // IDLE and ALERT share one selection rule; ALERT holds while req[2].
      default: begin
        dwell_d = '0;
        if (req[SRC_ALERT]) begin
          state_d = ST_ALERT;
          src_d   = SRC_ALERT;
        end else if (|req[1:0]) begin
          state_d   = ST_ROTATE;
          src_d     = {1'b0, idle_pick};
          rr_next_d = ~idle_pick;
        end else begin
          state_d = ST_IDLE;
          src_d   = SRC_NONE;
        end
      end
    endcase
  end

  // Output next values follow the newly selected source's live inputs.
  always_comb begin
    disp_d = '0;
    dps_d  = '0;
    case (src_d)
      SRC_TIME:  begin disp_d = data0; dps_d = dp0; end
      SRC_DATE:  begin disp_d = data1; dps_d = dp1; end
      SRC_ALERT: begin disp_d = data2; dps_d = dp2; end
      default:   begin disp_d = '0;    dps_d = '0;  end
    endcase

    if (src_d == SRC_NONE) begin
      den_d = 4'h0;
    end else if (blink_x[src_d] && blink_phase) begin
      den_d = 4'h0;
    end else begin
      den_d = 4'hF;
    end

    sw_d = (src_d != src_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      src_q     <= SRC_NONE;
      dwell_q   <= '0;
      rr_next_q <= 1'b0;
      disp_q    <= '0;
      dps_q     <= '0;
      den_q     <= '0;
      sw_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dwell_q   <= dwell_d;
      rr_next_q <= rr_next_d;
      disp_q    <= disp_d;
      dps_q     <= dps_d;
      den_q     <= den_d;
      sw_q      <= sw_d;
    end
  end

  assign hexa3      = disp_q[15:12];
  assign hexa2      = disp_q[11:8];
  assign hexa1      = disp_q[7:4];
  assign hexa0      = disp_q[3:0];
  assign dps        = dps_q;
  assign digit_en   = den_q;
  assign active_src = src_q;
  assign switched   = sw_q;

endmodule

// File: tb/tb_sseg_scheduler.sv
// Self-checking bench for sseg_scheduler with DWELL_CYCLES = 8, BLINK_CYCLES = 3.
module tb_sseg_scheduler;

  localparam int unsigned DW = 8;
  localparam int unsigned BC = 3;
  localparam int unsigned CW = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req = 3'b000;
  logic [2:0]  blink = 3'b000;
  logic [15:0] data0 = 16'h1234;
  logic [15:0] data1 = 16'h0811;
  logic [15:0] data2 = 16'hABCD;
  logic [3:0]  dp0 = 4'h4;
  logic [3:0]  dp1 = 4'h0;
  logic [3:0]  dp2 = 4'hF;
  logic [3:0]  hexa3, hexa2, hexa1, hexa0, dps, digit_en;
  logic [1:0]  active_src;
  logic        switched;

  int checks = 0;
  int errors = 0;

  sseg_scheduler #(
    .DWELL_CYCLES (DW),
    .BLINK_CYCLES (BC),
    .CNT_W        (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .blink      (blink),
    .data0      (data0),
    .data1      (data1),
    .data2      (data2),
    .dp0        (dp0),
    .dp1        (dp1),
    .dp2        (dp2),
    .hexa3      (hexa3),
    .hexa2      (hexa2),
    .hexa1      (hexa1),
    .hexa0      (hexa0),
    .dps        (dps),
    .digit_en   (digit_en),
    .active_src (active_src),
    .switched   (switched)
  );

  always #5 clk = ~clk;

  // One row: hold inputs for n cycles; expect src/den on every cycle,
  // switched = sw on the first cycle and 0 afterwards.
  typedef struct {
    logic       rst;
    logic [2:0] req;
    int         n;
    logic [1:0] src;
    logic       sw;
    logic [3:0] den;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic rst, input logic [2:0] rq, input int n,
                              input logic [1:0] src, input logic sw, input logic [3:0] den);
    vec_t v;
    v.rst = rst; v.req = rq; v.n = n; v.src = src; v.sw = sw; v.den = den;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [15:0] exp_data;
  logic [3:0]  exp_dp;

  initial begin
    // Scenario 1: reset with all requests, then alert wins.
    vecs[0]  = mk(1'b1, 3'b111, 2,  2'd3, 1'b0, 4'h0);
    vecs[1]  = mk(1'b0, 3'b111, 3,  2'd2, 1'b1, 4'hF);
    // Scenario 2: rotation 0,1,0, each 8 cycles (last leg cut at dwell 3).
    vecs[2]  = mk(1'b1, 3'b011, 1,  2'd3, 1'b0, 4'h0);
    vecs[3]  = mk(1'b0, 3'b011, 8,  2'd0, 1'b1, 4'hF);
    vecs[4]  = mk(1'b0, 3'b011, 8,  2'd1, 1'b1, 4'hF);
    vecs[5]  = mk(1'b0, 3'b011, 4,  2'd0, 1'b1, 4'hF);
    // Scenario 3: alert pre-empts source 0 at dwell 3; resume on rr_next = 1.
    vecs[6]  = mk(1'b0, 3'b111, 5,  2'd2, 1'b1, 4'hF);
    vecs[7]  = mk(1'b0, 3'b011, 8,  2'd1, 1'b1, 4'hF);
    vecs[8]  = mk(1'b0, 3'b011, 8,  2'd0, 1'b1, 4'hF);
    // Scenario 4: only source 0 across three dwells, then drop mid-dwell.
    vecs[9]  = mk(1'b1, 3'b000, 1,  2'd3, 1'b0, 4'h0);
    vecs[10] = mk(1'b0, 3'b001, 28, 2'd0, 1'b1, 4'hF);
    vecs[11] = mk(1'b0, 3'b000, 2,  2'd3, 1'b1, 4'h0);
    // Scenario 6: rr_next = 1 picks source 1; alert on its expiry cycle.
    vecs[12] = mk(1'b0, 3'b011, 7,  2'd1, 1'b1, 4'hF);
    vecs[13] = mk(1'b0, 3'b011, 1,  2'd1, 1'b0, 4'hF);
    vecs[14] = mk(1'b0, 3'b111, 3,  2'd2, 1'b1, 4'hF);
    vecs[15] = mk(1'b1, 3'b111, 1,  2'd3, 1'b0, 4'h0);
    vecs[16] = mk(1'b0, 3'b000, 2,  2'd3, 1'b0, 4'h0);

    @(negedge clk);
    for (int r = 0; r < NV; r++) begin
      reset = vecs[r].rst;
      req   = vecs[r].req;
      blink = 3'b000;
      for (int i = 0; i < vecs[r].n; i++) begin
        tick();
        check($sformatf("row%0d.%0d src", r, i), 32'(active_src), 32'(vecs[r].src));
        check($sformatf("row%0d.%0d switched", r, i), 32'(switched),
              (i == 0) ? 32'(vecs[r].sw) : 32'd0);
        check($sformatf("row%0d.%0d digit_en", r, i), 32'(digit_en), 32'(vecs[r].den));
        if (vecs[r].rst || vecs[r].src != 2'd3) begin
          exp_data = 16'h0;
          exp_dp   = 4'h0;
          if (!vecs[r].rst) begin
            case (vecs[r].src)
              2'd0:    begin exp_data = data0; exp_dp = dp0; end
              2'd1:    begin exp_data = data1; exp_dp = dp1; end
              default: begin exp_data = data2; exp_dp = dp2; end
            endcase
          end
          check($sformatf("row%0d.%0d hexa", r, i),
                32'({hexa3, hexa2, hexa1, hexa0}), 32'(exp_data));
          check($sformatf("row%0d.%0d dps", r, i), 32'(dps), 32'(exp_dp));
        end
      end
    end

    // Scenario 5: blink on source 0. Blink phase is 1 during cycles 3..5
    // after release; digit_en follows it one cycle later (registered).
    reset = 1'b1;
    req   = 3'b001;
    blink = 3'b001;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("blink%0d digit_en", i), 32'(digit_en),
            (((i / 3) % 2) == 1) ? 32'h0 : 32'hF);
      check($sformatf("blink%0d src", i), 32'(active_src), 32'd0);
      check($sformatf("blink%0d hexa", i), 32'({hexa3, hexa2, hexa1, hexa0}), 32'h1234);
    end
    blink = 3'b000;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("noblink%0d digit_en", i), 32'(digit_en), 32'hF);
    end

    // Live data propagates with one cycle of latency.
    data0 = 16'h5678;
    dp0   = 4'h9;
    tick();
    check("live hexa", 32'({hexa3, hexa2, hexa1, hexa0}), 32'h5678);
    check("live dps", 32'(dps), 32'h9);
    check("live no switch", 32'(switched), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
